branch_resolve_unit: RTL

//   Resolves control-flow instructions: evaluates the branch condition, computes the

---
 rtl/branch_resolve_unit.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
// Control-flow resolution: condition evaluation, target/link generation and
// alignment check, behind a valid/ready register pipeline with flush.
module branch_resolve_unit #(
   parameter int XLEN        = 32,
   parameter int ALUCODE_W   = 6,
   parameter int PIPE_STAGES = 1,
   parameter int IALIGN      = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ALUCODE_W-1:0] alucode,
   input  logic [XLEN-1:0]      pc,
   input  logic [XLEN-1:0]      rs1,
   input  logic [XLEN-1:0]      rs2,
   input  logic [XLEN-1:0]      imm,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_is_cf,
   output logic                 out_taken,
   output logic [XLEN-1:0]      out_target,
   output logic [XLEN-1:0]      out_link,
   output logic                 out_misalign,
   output logic [XLEN-1:0]      taken_count
);

   localparam logic [ALUCODE_W-1:0] ALU_JAL  = ALUCODE_W'(20);
   localparam logic [ALUCODE_W-1:0] ALU_JALR = ALUCODE_W'(21);
   localparam logic [ALUCODE_W-1:0] ALU_BEQ  = ALUCODE_W'(22);
   localparam logic [ALUCODE_W-1:0] ALU_BNE  = ALUCODE_W'(23);
   localparam logic [ALUCODE_W-1:0] ALU_BLT  = ALUCODE_W'(24);
   localparam logic [ALUCODE_W-1:0] ALU_BGE  = ALUCODE_W'(25);
   localparam logic [ALUCODE_W-1:0] ALU_BLTU = ALUCODE_W'(26);
   localparam logic [ALUCODE_W-1:0] ALU_BGEU = ALUCODE_W'(27);

   // 16-bit alignment only needs target[0]; 32-bit needs target[1:0]
   localparam logic [1:0] ALIGN_MASK = (IALIGN == 16) ? 2'b01 : 2'b11;

   typedef struct packed {
      logic            is_cf;
      logic            taken;
      logic [XLEN-1:0] target;
      logic [XLEN-1:0] link;
      logic            misalign;
   } res_t;

   logic [XLEN-1:0] seq_pc;
   logic [XLEN-1:0] br_tgt;
   logic [XLEN-1:0] jalr_sum;
   logic            is_br;
   logic            cond;
   res_t            res;

   always_comb begin
      seq_pc     = pc + XLEN'(4);
      br_tgt     = pc + imm;
      jalr_sum   = rs1 + imm;
      is_br      = 1'b0;
      cond       = 1'b0;
      res        = '0;
      res.target = seq_pc;
      case (alucode)
         ALU_JAL: begin
            res.is_cf  = 1'b1;
            res.taken  = 1'b1;
            res.target = br_tgt;
            res.link   = seq_pc;
         end
         ALU_JALR: begin
            res.is_cf  = 1'b1;
            res.taken  = 1'b1;
            res.target = jalr_sum & ~XLEN'(1);
            res.link   = seq_pc;
         end
         ALU_BEQ:  begin is_br = 1'b1; cond = (rs1 == rs2); end
         ALU_BNE:  begin is_br = 1'b1; cond = (rs1 != rs2); end
         ALU_BLT:  begin is_br = 1'b1; cond = ($signed(rs1) <  $signed(rs2)); end
         ALU_BGE:  begin is_br = 1'b1; cond = ($signed(rs1) >= $signed(rs2)); end
         ALU_BLTU: begin is_br = 1'b1; cond = (rs1 <  rs2); end
         ALU_BGEU: begin is_br = 1'b1; cond = (rs1 >= rs2); end
         default: ;
      endcase
      if (is_br) begin
         res.is_cf = 1'b1;
         res.taken = cond;
         if (cond) res.target = br_tgt;
      end
      res.misalign = res.taken && (|(res.target[1:0] & ALIGN_MASK));
   end

   logic st_v  [PIPE_STAGES];
   res_t st_d  [PIPE_STAGES];
   logic src_v [PIPE_STAGES];
   res_t src_d [PIPE_STAGES];
   logic rdy   [PIPE_STAGES+1];

   always_comb begin
      src_v[0] = in_valid;
      src_d[0] = res;
      for (int unsigned k = 1; k < PIPE_STAGES; k++) begin
         src_v[k] = st_v[k-1];
         src_d[k] = st_d[k-1];
      end
   end

   // Ready ripples back from the consumer; an empty stage always accepts
   always_comb begin
      rdy[PIPE_STAGES] = out_ready;
      for (int unsigned j = 0; j < PIPE_STAGES; j++) begin
         rdy[PIPE_STAGES-1-j] = !st_v[PIPE_STAGES-1-j] || rdy[PIPE_STAGES-j];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
            st_v[k] <= 1'b0;
            st_d[k] <= '0;
         end
         taken_count <= '0;
      end else begin
         if (out_valid && out_ready && out_taken) taken_count <= taken_count + XLEN'(1);
         for (int unsigned k = 0; k < PIPE_STAGES; k++) begin
            if (flush) begin
               st_v[k] <= 1'b0;
            end else if (rdy[k]) begin
               st_v[k] <= src_v[k];
               if (src_v[k]) st_d[k] <= src_d[k];
            end
         end
      end
   end

   assign in_ready     = rdy[0];
   assign out_valid    = st_v[PIPE_STAGES-1];
   assign out_is_cf    = st_d[PIPE_STAGES-1].is_cf;
   assign out_taken    = st_d[PIPE_STAGES-1].taken;
   assign out_target   = st_d[PIPE_STAGES-1].target;
   assign out_link     = st_d[PIPE_STAGES-1].link;
   assign out_misalign = st_d[PIPE_STAGES-1].misalign;

endmodule
